ap_dma_scheduler: RTL



---
 rtl/ap_pkg.sv | 29 ++
 rtl/ap_eaq_rr_sel.sv | 48 ++++
 rtl/ap_dma_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ap_pkg.sv
// ============================================================================
// ap_pkg: opcodes, FSM state encoding, default bursts and err bit indices
// shared by the AP DMA scheduler.  Revision: 1.0
// ============================================================================
`default_nettype none

package ap_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RD_XFER = 3'd2,
    WR_XFER = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int DEF_RD_BURST = 8;
  localparam int DEF_WR_BURST = 16;

  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_TIMEOUT = 1;

endpackage

`default_nettype wire

// File: rtl/ap_eaq_rr_sel.sv
// ============================================================================
// ap_eaq_rr_sel: strict EAQ1/EAQ2 alternating selector with pop/data muxing;
// pointer returns to EAQ1 on load.  Revision: 1.0
// ============================================================================
`default_nettype none

module ap_eaq_rr_sel
  import ap_pkg::*;
#(
  parameter int BITLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic              eaq1_empty,
  input  logic              eaq2_empty,
  input  logic [BITLEN-1:0] eaq1_dout,
  input  logic [BITLEN-1:0] eaq2_dout,
  output logic              eaq1_rd_en,
  output logic              eaq2_rd_en,
  output logic [BITLEN-1:0] dout,
  output logic              beat
);

  // 0 selects EAQ1, 1 selects EAQ2; the other queue is never popped out of turn
  logic r_sel;
  logic w_sel_empty;

  assign w_sel_empty = r_sel ? eaq2_empty : eaq1_empty;
  assign beat        = en && !w_sel_empty;
  assign eaq1_rd_en  = beat && !r_sel;
  assign eaq2_rd_en  = beat && r_sel;
  assign dout        = beat ? (r_sel ? eaq2_dout : eaq1_dout) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 1'b0;
    end else if (load) begin
      r_sel <= 1'b0;
    end else if (beat) begin
      r_sel <= ~r_sel;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ap_dma_scheduler.sv
// ============================================================================
// ap_dma_scheduler: pops instructions, issues DMA commands, runs counted READ
// / WRITE bursts. Optional stall timeout: AP_SCHED_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module ap_dma_scheduler
  import ap_pkg::*;
#(
  parameter int ISA         = 2,
  parameter int ADDR        = 32,
  parameter int BITLEN      = 64,
  parameter int RD_BURST    = DEF_RD_BURST,
  parameter int WR_BURST    = DEF_WR_BURST
`ifdef AP_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                isa_empty,
  input  logic [ISA+ADDR-1:0] isa_dout,
  output logic                isa_rd_en,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_write,
  output logic [ADDR-1:0]     cmd_addr,
  output logic [7:0]          cmd_burst,
  input  logic                dma1_empty,
  input  logic [BITLEN-1:0]   dma1_dout,
  output logic                dma1_rd_en,
  input  logic                aeq_full,
  output logic [BITLEN-1:0]   aeq_din,
  output logic                aeq_wr_en,
  input  logic                eaq1_empty,
  input  logic                eaq2_empty,
  input  logic [BITLEN-1:0]   eaq1_dout,
  input  logic [BITLEN-1:0]   eaq2_dout,
  output logic                eaq1_rd_en,
  output logic                eaq2_rd_en,
  input  logic                dma2_full,
  output logic [BITLEN-1:0]   dma2_din,
  output logic                dma2_wr_en,
  input  logic                err_clr,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err
);

  state_t          state, state_nx;
  logic [ISA-1:0]  w_op;
  logic [ADDR-1:0] w_addr;
  logic            w_pop;
  logic            w_xfer_op;
  logic            w_illegal;
  logic            w_rd_beat;
  logic            w_wr_en;
  logic            w_wr_beat;
  logic            w_last;
  logic            w_timeout;
  logic [7:0]      r_beat;
  logic [1:0]      r_err;

  assign w_op      = isa_dout[ISA+ADDR-1:ADDR];
  assign w_addr    = isa_dout[ADDR-1:0];
  assign w_xfer_op = (w_op == ISA'(OP_READ)) || (w_op == ISA'(OP_WRITE));

  // Every strobe is gated by reset so that asserting it clears all outputs at once
  assign w_pop     = (state == IDLE) && !isa_empty && !rst_n;
  assign w_illegal = w_pop && !w_xfer_op && (w_op != ISA'(OP_NOP));
  assign w_rd_beat = (state == RD_XFER) && !dma1_empty && !aeq_full && !rst_n;
  assign w_wr_en   = (state == WR_XFER) && !dma2_full && !rst_n;
  assign w_last    = (r_beat == cmd_burst - 8'd1);

  assign isa_rd_en  = w_pop;
  assign dma1_rd_en = w_rd_beat;
  assign aeq_wr_en  = w_rd_beat;
  assign aeq_din    = w_rd_beat ? dma1_dout : '0;
  assign dma2_wr_en = w_wr_beat;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = r_err;

  ap_eaq_rr_sel #(
    .BITLEN (BITLEN)
  ) u_eaq_sel (
    .clk        (clk),
    .rst        (rst_n),
    .load       (state == CMD),
    .en         (w_wr_en),
    .eaq1_empty (eaq1_empty),
    .eaq2_empty (eaq2_empty),
    .eaq1_dout  (eaq1_dout),
    .eaq2_dout  (eaq2_dout),
    .eaq1_rd_en (eaq1_rd_en),
    .eaq2_rd_en (eaq2_rd_en),
    .dout       (dma2_din),
    .beat       (w_wr_beat)
  );

`ifdef AP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] r_stall;
  logic          w_active;
  logic          w_progress;

  assign w_active   = (state == CMD) || (state == RD_XFER) || (state == WR_XFER);
  assign w_progress = ((state == CMD) && cmd_ready) || w_rd_beat || w_wr_beat;
  assign w_timeout  = w_active && !w_progress && (r_stall == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_stall <= '0;
    end else if (!w_active || w_progress || (state_nx != state)) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (w_pop && w_xfer_op) state_nx = CMD;
      CMD:     if (cmd_ready) state_nx = cmd_write ? WR_XFER : RD_XFER;
      RD_XFER: if (w_rd_beat && w_last) state_nx = DONE;
      WR_XFER: if (w_wr_beat && w_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (w_timeout) state_nx = DONE;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_burst <= '0;
      r_beat    <= '0;
    end else begin
      state     <= state_nx;
      cmd_valid <= (state_nx == CMD);
      if (w_pop) begin
        cmd_write <= w_op[1];
        cmd_addr  <= w_addr;
        cmd_burst <= w_op[1] ? 8'(WR_BURST) : 8'(RD_BURST);
      end
      if (state == CMD) begin
        r_beat <= '0;
      end else if (w_rd_beat || w_wr_beat) begin
        r_beat <= r_beat + 8'd1;
      end
    end
  end

  // A new error event in the same cycle as err_clr keeps the bit set
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_err <= '0;
    end else begin
      if (w_illegal) begin
        r_err[ERR_ILLEGAL] <= 1'b1;
      end else if (err_clr) begin
        r_err[ERR_ILLEGAL] <= 1'b0;
      end
`ifdef AP_SCHED_TIMEOUT_EN
      if (w_timeout) begin
        r_err[ERR_TIMEOUT] <= 1'b1;
      end else if (err_clr) begin
        r_err[ERR_TIMEOUT] <= 1'b0;
      end
`else
      r_err[ERR_TIMEOUT] <= 1'b0;
`endif
    end
  end

endmodule

`default_nettype wire
